// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: ALU opcodes and FSM state encoding.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_LESS = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_MOD  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PTR_W-1:0]   idx
);

  always_comb begin
    logic        found;
    int unsigned pos;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = 32'(ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && pos == i && req[i]) begin
          found     = 1'b1;
          onehot[i] = 1'b1;
          idx       = PTR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multicycle ALU between NUM_REQ requesters with round-robin grants,
// a single outstanding operation and a watchdog abort on a missing We.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*DATA_W-1:0] ReqA,
  input  logic [NUM_REQ*DATA_W-1:0] ReqB,
  input  logic [NUM_REQ*3-1:0]      ReqOp,
  output logic [NUM_REQ-1:0]        Gnt,
  output logic [NUM_REQ-1:0]        RspValid,
  output logic [DATA_W-1:0]         RspResult,
  output logic                      RspC,
  output logic                      RspErr,
  output logic                      Busy,
  output logic [DATA_W-1:0]         AluA,
  output logic [DATA_W-1:0]         AluB,
  output logic [2:0]                AluOp,
  input  logic [DATA_W-1:0]         AluResult,
  input  logic                      AluC,
  input  logic                      AluWe
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  state_t               state, state_d;
  logic [PTR_W-1:0]     ptr, ptr_d;
  logic [PTR_W-1:0]     win, win_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [NUM_REQ-1:0]   gnt_d, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_result_d, alu_a_d, alu_b_d;
  logic                 rsp_c_d, rsp_err_d, busy_d;
  logic [2:0]           alu_op_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]     pick_idx;
  logic [DATA_W-1:0]    sel_a, sel_b;
  logic [2:0]           sel_op;
  logic [NUM_REQ-1:0]   win_onehot;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_rr (
    .req   (Req),
    .ptr   (ptr),
    .onehot(pick_onehot),
    .idx   (pick_idx)
  );

  // Operand mux for the requester the picker chose this cycle.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        sel_a  = ReqA[i*DATA_W +: DATA_W];
        sel_b  = ReqB[i*DATA_W +: DATA_W];
        sel_op = ReqOp[i*3 +: 3];
      end
    end
  end

  assign win_onehot = NUM_REQ'(1) << win;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    win_d        = win;
    cnt_d        = cnt;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_result_d = '0;
    rsp_c_d      = 1'b0;
    rsp_err_d    = 1'b0;
    alu_a_d      = AluA;
    alu_b_d      = AluB;
    alu_op_d     = AluOp;
    unique case (state)
      ST_IDLE: begin
        if (|Req) begin
          win_d    = pick_idx;
          gnt_d    = pick_onehot;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          ptr_d    = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        // A We seen in the first WAIT cycle belongs to the previous operation.
        if (AluWe && cnt != '0) begin
          rsp_valid_d  = win_onehot;
          rsp_result_d = AluResult;
          rsp_c_d      = AluC;
          state_d      = ST_RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rsp_valid_d = win_onehot;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      Gnt       <= '0;
      RspValid  <= '0;
      RspResult <= '0;
      RspC      <= 1'b0;
      RspErr    <= 1'b0;
      Busy      <= 1'b0;
      AluA      <= '0;
      AluB      <= '0;
      AluOp     <= OP_AND;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      win       <= win_d;
      cnt       <= cnt_d;
      Gnt       <= gnt_d;
      RspValid  <= rsp_valid_d;
      RspResult <= rsp_result_d;
      RspC      <= rsp_c_d;
      RspErr    <= rsp_err_d;
      Busy      <= busy_d;
      AluA      <= alu_a_d;
      AluB      <= alu_b_d;
      AluOp     <= alu_op_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; the bench plays the ALU by hand.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic                      Clk;
  logic                      Reset_n;
  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*DATA_W-1:0] ReqA;
  logic [NUM_REQ*DATA_W-1:0] ReqB;
  logic [NUM_REQ*3-1:0]      ReqOp;
  logic [NUM_REQ-1:0]        Gnt;
  logic [NUM_REQ-1:0]        RspValid;
  logic [DATA_W-1:0]         RspResult;
  logic                      RspC;
  logic                      RspErr;
  logic                      Busy;
  logic [DATA_W-1:0]         AluA;
  logic [DATA_W-1:0]         AluB;
  logic [2:0]                AluOp;
  logic [DATA_W-1:0]         AluResult;
  logic                      AluC;
  logic                      AluWe;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Req      (Req),
    .ReqA     (ReqA),
    .ReqB     (ReqB),
    .ReqOp    (ReqOp),
    .Gnt      (Gnt),
    .RspValid (RspValid),
    .RspResult(RspResult),
    .RspC     (RspC),
    .RspErr   (RspErr),
    .Busy     (Busy),
    .AluA     (AluA),
    .AluB     (AluB),
    .AluOp    (AluOp),
    .AluResult(AluResult),
    .AluC     (AluC),
    .AluWe    (AluWe)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: grant, WAIT (We at cnt==we_cnt, or timeout when we_cnt<=0), response, idle.
  task automatic run_op(input logic [1:0] req, input int win, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] op, input int we_cnt,
                        input logic [31:0] res, input logic c, input logic stale,
                        input logic drop, input string tag);
    int         last;
    logic       err;
    logic [1:0] g;
    g   = 2'(1 << win);
    err = (we_cnt <= 0);
    Req = req;
    step();
    chk({tag, ".gnt"}, 64'(Gnt), 64'(g));
    chk({tag, ".alu_a"}, 64'(AluA), 64'(a));
    chk({tag, ".alu_b"}, 64'(AluB), 64'(b));
    chk({tag, ".alu_op"}, 64'(AluOp), 64'(op));
    chk({tag, ".busy"}, 64'(Busy), 64'(1));
    if (drop) Req = 2'b00;
    step();
    chk({tag, ".gnt_clr"}, 64'(Gnt), 64'(0));
    AluWe     = stale;
    AluC      = stale;
    AluResult = 32'hDEAD_BEEF;
    last = (we_cnt > 0) ? we_cnt : int'(TIMEOUT) - 1;
    for (int k = 1; k <= last; k++) begin
      step();
      chk({tag, ".wait_rsp"}, 64'(RspValid), 64'(0));
      chk({tag, ".wait_ops"}, {AluA, AluB}, {a, b});
      chk({tag, ".wait_op"}, 64'(AluOp), 64'(op));
      if (k == we_cnt) begin
        AluWe     = 1'b1;
        AluResult = res;
        AluC      = c;
      end else begin
        AluWe     = 1'b0;
        AluResult = 32'hDEAD_BEEF;
        AluC      = 1'b1;
      end
    end
    step();
    chk({tag, ".rsp_valid"}, 64'(RspValid), 64'(g));
    chk({tag, ".rsp_result"}, 64'(RspResult), err ? 64'(0) : 64'(res));
    chk({tag, ".rsp_c"}, 64'(RspC), err ? 64'(0) : 64'(c));
    chk({tag, ".rsp_err"}, 64'(RspErr), 64'(err));
    AluWe = 1'b0;
    AluC  = 1'b0;
    step();
    chk({tag, ".idle_rsp"}, 64'(RspValid), 64'(0));
    chk({tag, ".idle_result"}, 64'(RspResult), 64'(0));
    chk({tag, ".idle_err"}, 64'(RspErr), 64'(0));
    chk({tag, ".idle_busy"}, 64'(Busy), 64'(0));
    chk({tag, ".idle_alu_hold"}, 64'(AluOp), 64'(op));
  endtask

  initial begin
    Reset_n   = 1'b0;
    Req       = '0;
    ReqA      = '0;
    ReqB      = '0;
    ReqOp     = '0;
    AluResult = '0;
    AluC      = 1'b0;
    AluWe     = 1'b0;

    // Reset held for two cycles.
    step();
    step();
    chk("rst.gnt", 64'(Gnt), 64'(0));
    chk("rst.rsp", 64'(RspValid), 64'(0));
    chk("rst.busy", 64'(Busy), 64'(0));
    chk("rst.alu", {AluA, AluB}, 64'(0));
    chk("rst.alu_op", 64'(AluOp), 64'(OP_AND));
    chk("rst.result", {RspResult, 30'd0, RspC, RspErr}, 64'(0));
    Reset_n = 1'b1;
    step();
    step();
    chk("post_rst.busy", 64'(Busy), 64'(0));
    chk("post_rst.gnt", 64'(Gnt), 64'(0));

    // Single ADD 7+5 from requester 0 (ptr -> 1).
    ReqA  = {32'd0, 32'd7};
    ReqB  = {32'd0, 32'd5};
    ReqOp = {3'd0, OP_ADD};
    run_op(2'b01, 0, 32'd7, 32'd5, OP_ADD, 1, 32'd12, 1'b0, 1'b0, 1'b1, "add");

    // Timeout on requester 1 (ptr -> 0); AluResult held non-zero to show it is discarded.
    ReqA  = {32'h1234_5678, 32'd0};
    ReqB  = {32'h0000_0001, 32'd0};
    ReqOp = {OP_XOR, 3'd0};
    run_op(2'b10, 1, 32'h1234_5678, 32'h1, OP_XOR, 0, 32'h0, 1'b0, 1'b0, 1'b1, "tmo");

    // Fairness with both requesting: AND on 0, OR on 1, alternating.
    ReqA  = {32'h0000_000F, 32'h0000_F0F0};
    ReqB  = {32'h0000_00F0, 32'h0000_FF00};
    ReqOp = {OP_OR, OP_AND};
    run_op(2'b11, 0, 32'h0000_F0F0, 32'h0000_FF00, OP_AND, 1, 32'h0000_F000, 1'b0, 1'b0, 1'b0, "fair0");
    run_op(2'b11, 1, 32'h0000_000F, 32'h0000_00F0, OP_OR, 2, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, "fair1");
    run_op(2'b11, 0, 32'h0000_F0F0, 32'h0000_FF00, OP_AND, 1, 32'h0000_F000, 1'b0, 1'b0, 1'b0, "fair2");
    run_op(2'b11, 1, 32'h0000_000F, 32'h0000_00F0, OP_OR, 1, 32'h0000_00FF, 1'b1, 1'b0, 1'b1, "fair3");

    // Multicycle MOD 42%11 with a stale We in the first WAIT cycle.
    ReqA  = {32'd0, 32'd42};
    ReqB  = {32'd0, 32'd11};
    ReqOp = {3'd0, OP_MOD};
    run_op(2'b01, 0, 32'd42, 32'd11, OP_MOD, 5, 32'd9, 1'b0, 1'b1, 1'b1, "mod");

    // Reset asserted mid-WAIT drops the operation silently.
    Req = 2'b01;
    step();
    chk("rstmid.gnt", 64'(Gnt), 64'(2'b01));
    Req = 2'b00;
    step();
    step();
    chk("rstmid.busy_pre", 64'(Busy), 64'(1));
    Reset_n = 1'b0;
    #1;
    chk("rstmid.busy", 64'(Busy), 64'(0));
    chk("rstmid.alu", {AluA, AluB}, 64'(0));
    chk("rstmid.alu_op", 64'(AluOp), 64'(OP_AND));
    chk("rstmid.gnt_rsp", {Gnt, RspValid}, 64'(0));
    AluWe     = 1'b1;
    AluResult = 32'd9;
    step();
    step();
    chk("rstmid.no_rsp", 64'(RspValid), 64'(0));
    AluWe     = 1'b0;
    AluResult = '0;
    Reset_n   = 1'b1;
    step();
    chk("rstmid.idle", 64'(Busy), 64'(0));

    // Post-reset SUB 10-3 from requester 1.
    ReqA  = {32'd10, 32'd0};
    ReqB  = {32'd3, 32'd0};
    ReqOp = {OP_SUB, 3'd0};
    run_op(2'b10, 1, 32'd10, 32'd3, OP_SUB, 1, 32'd7, 1'b0, 1'b0, 1'b1, "sub");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
